fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer that owns the fetch PC and the 4-instruction (128-bit) line buffer feeding the fetch datapath. It issues line requests to instruction memory over a valid/ready handshake and reuses the buffered line while the next PC stays in it. It also redirects on branch mispredict, dropping any in-flight stale response. It sits between instruction memory and the fetch datapath (PC/`idata` consumer, `npc` producer), with decode back-pressure via `stall_if`.

## Interface
Parameters:
- `ENTRY_POINT`, default `ADDR_LEN'h0`: PC loaded on reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `stall_if`  in  1  decode cannot accept this cycle's fetch group.
- `prmiss`  in  1  mispredict redirect.
- `jmpaddr`  in  `ADDR_LEN`  redirect target; valid when `prmiss`=1.
- `npc`  in  `ADDR_LEN`  next PC computed by the fetch datapath from `pc`.
- `pc`  out  `ADDR_LEN`  current fetch PC.
- `idata`  out  `4*INSN_LEN`  buffered line.
- `fetch_valid`  out  1  `pc`/`idata` form a valid fetch group this cycle.
- `imem_req_valid`  out  1  line request.
- `imem_req_addr`  out  `ADDR_LEN`  `{pc[ADDR_LEN-1:4],4'b0}`.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  line returned; exactly one response per accepted request, in order.
- `imem_resp_data`  in  `4*INSN_LEN`  returned line.

## Operation
- Registers:
  - `pc`
  - `state`
  - `line_tag` (`ADDR_LEN-4` bits)
  - `idata`
- Hit: `npc[ADDR_LEN-1:4]==line_tag`.
- States: IDLE, REQ, WAIT, DRAIN, VALID. `prmiss` has priority over `stall_if` in every state.
- IDLE:
  - Outputs idle.
  - Next state is always REQ.
- REQ:
  - `imem_req_valid`=1.
  - `prmiss`&!`ready`: `pc<=jmpaddr`, stay REQ. The address may change while unaccepted; memory samples only on valid&ready.
  - `prmiss`&`ready`: the request carries the old address. `pc<=jmpaddr`, go to DRAIN.
  - `ready` alone: go to WAIT.
- WAIT:
  - `imem_resp_valid` alone: `idata<=resp_data`, `line_tag<=pc[ADDR_LEN-1:4]`, go to VALID.
  - `prmiss` alone: `pc<=jmpaddr`, go to DRAIN.
  - `prmiss`&`resp_valid`: discard the response, `pc<=jmpaddr`, go to REQ.
- DRAIN:
  - `resp_valid`: discard, go to REQ.
  - `prmiss`: `pc<=jmpaddr`, stay in DRAIN.
  - Both together: discard, update `pc`, go to REQ.
- VALID:
  - `fetch_valid`=1.
  - `prmiss`: `pc<=jmpaddr`. Stay in VALID if `jmpaddr` hits `line_tag`, else go to REQ.
  - `stall_if`: hold everything.
  - Otherwise: `pc<=npc`. Stay in VALID on hit, else go to REQ.
- `imem_resp_valid` in IDLE/REQ/VALID is a protocol violation: ignore it; the bench asserts on it.
- `fetch_valid`=0 in all states except VALID.

## Timing
- Reset values, present on the cycle after any reset edge:
  - `pc`=`ENTRY_POINT`, state IDLE.
  - `fetch_valid`=0, `imem_req_valid`=0.
  - `idata`=0, `line_tag`=0.
- Reset mid-request abandons any outstanding transaction. The memory side is reset on the same signal.
- `imem_req_valid` first rises 1 cycle after reset deasserts.
- Outputs are decoded from registered state; there is no combinational path from `imem_resp_*` to `idata` or `fetch_valid`.
- Miss latency: request accepted at cycle t, response at t+k (k≥1), `fetch_valid` at t+k+1.
- Hit streaming: one fetch group per cycle, no bubbles.
- Redirect to a hit target: `fetch_valid` stays high, with the new `pc` on the next cycle.
- Redirect to a miss target: `imem_req_valid` is asserted on the next cycle.

## Structure
- Put the state encodings (`FC_IDLE`..`FC_VALID`, 3-bit) and `FC_TAG_LEN` (=`ADDR_LEN-4`) in `constants.vh`.
- Sub-module `fetch_line_buf`:
  - Holds `idata`, `line_tag` and the hit compare.
  - Inputs: `we`, `wtag`, `wdata`, `lookup`.
  - Output: `hit`.
- The FSM and `pc` stay in `fetch_ctrl`.

## Test plan
- Reset with `ENTRY_POINT`=0x100, ready=1, response latency 1 -> `imem_req_addr`=0x100 at cycle 1, `fetch_valid` at cycle 3 with `pc`=0x100.
- `npc`=pc+8 from 0x100 -> groups at 0x100 and 0x108 back-to-back with a single request. At 0x110 a new request is issued; no `fetch_valid` for 2 cycles.
- `prmiss` in WAIT with `jmpaddr`=0x400, stale response 3 cycles later -> stale data is never presented. The next request is 0x400 and `fetch_valid` has `pc`=0x400.
- `prmiss` and `imem_resp_valid` in the same WAIT cycle, `jmpaddr`=0x20C -> response discarded, REQ next with address 0x200.
- `stall_if`=1 for 4 cycles in VALID -> `pc` and `idata` held, no request. A `prmiss` during the stall to a same-line target updates `pc` immediately.
- `reset` asserted while in WAIT -> IDLE on the next cycle, `pc`=`ENTRY_POINT`. A late response afterwards is ignored and flagged by the bench.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, FSM state encodings and tag helper for the fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int INSN_LEN   = 32;
    localparam int LINE_LEN   = 4 * INSN_LEN;
    localparam int FC_TAG_LEN = ADDR_LEN - 4;

    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_REQ   = 3'd1,
        FC_WAIT  = 3'd2,
        FC_DRAIN = 3'd3,
        FC_VALID = 3'd4
    } fc_state_t;

    // Line tag of a byte address: everything above the 16-byte line offset.
    function automatic logic [FC_TAG_LEN-1:0] tag_of(input logic [ADDR_LEN-1:0] addr);
        return addr[ADDR_LEN-1:4];
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory line request/response channel.
// Latency: n/a (wires only); one response per accepted request, in order.
// Backpressure: request held until req_ready; responses cannot be stalled.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                 imem_req_valid;
    logic [ADDR_LEN-1:0]  imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_resp_valid;
    logic [LINE_LEN-1:0]  imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );

endinterface

// File: rtl/fetch_line_buf.sv
// Single 128-bit instruction line plus its tag, with a combinational hit compare.
// Latency: write visible the cycle after we; hit is combinational on lookup.
// Backpressure: none; caller decides when to write.
module fetch_line_buf
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [FC_TAG_LEN-1:0] wtag,
    input  logic [LINE_LEN-1:0]   wdata,
    input  logic [FC_TAG_LEN-1:0] lookup,
    output logic [LINE_LEN-1:0]   idata,
    output logic                  hit
);

    logic [FC_TAG_LEN-1:0] line_tag;

    // Capture a returned line and the tag it was fetched for.
    always_ff @(posedge clk) begin
        if (reset) begin
            idata    <= '0;
            line_tag <= '0;
        end else if (we) begin
            idata    <= wdata;
            line_tag <= wtag;
        end
    end

    assign hit = (lookup == line_tag);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns pc, requests lines on a miss, streams hits, handles redirects.
// Latency: miss = accept + k response cycles + 1; hits stream one group per cycle.
// Backpressure: stall_if holds pc/idata in VALID; request held until imem_req_ready.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] ENTRY_POINT = {ADDR_LEN{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_if,
    input  logic                 prmiss,
    input  logic [ADDR_LEN-1:0]  jmpaddr,
    input  logic [ADDR_LEN-1:0]  npc,
    output logic [ADDR_LEN-1:0]  pc,
    output logic [LINE_LEN-1:0]  idata,
    output logic                 fetch_valid,
    fetch_ctrl_if.master         imem
);

    fc_state_t             state_q, state_d;
    logic [ADDR_LEN-1:0]   pc_q, pc_d;
    logic                  buf_we;
    logic                  hit;
    logic [FC_TAG_LEN-1:0] lookup_tag;

    // A redirect is checked against the buffered line, otherwise the sequential next pc.
    assign lookup_tag = prmiss ? tag_of(jmpaddr) : tag_of(npc);

    fetch_line_buf u_line_buf (
        .clk    (clk),
        .reset  (reset),
        .we     (buf_we),
        .wtag   (tag_of(pc_q)),
        .wdata  (imem.imem_resp_data),
        .lookup (lookup_tag),
        .idata  (idata),
        .hit    (hit)
    );

    // State and pc registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FC_IDLE;
            pc_q    <= ENTRY_POINT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and pc selection; redirect outranks stall everywhere.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_we  = 1'b0;
        case (state_q)
            FC_IDLE: begin
                state_d = FC_REQ;
            end
            FC_REQ: begin
                if (prmiss) begin
                    // An accepted request still carries the old address, so its reply is stale.
                    pc_d = jmpaddr;
                    if (imem.imem_req_ready) state_d = FC_DRAIN;
                end else if (imem.imem_req_ready) begin
                    state_d = FC_WAIT;
                end
            end
            FC_WAIT: begin
                if (prmiss) begin
                    pc_d    = jmpaddr;
                    state_d = imem.imem_resp_valid ? FC_REQ : FC_DRAIN;
                end else if (imem.imem_resp_valid) begin
                    buf_we  = 1'b1;
                    state_d = FC_VALID;
                end
            end
            FC_DRAIN: begin
                if (prmiss) pc_d = jmpaddr;
                if (imem.imem_resp_valid) state_d = FC_REQ;
            end
            FC_VALID: begin
                if (prmiss) begin
                    pc_d = jmpaddr;
                    if (!hit) state_d = FC_REQ;
                end else if (!stall_if) begin
                    pc_d = npc;
                    if (!hit) state_d = FC_REQ;
                end
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    assign pc                  = pc_q;
    assign fetch_valid         = (state_q == FC_VALID);
    assign imem.imem_req_valid = (state_q == FC_REQ);
    assign imem.imem_req_addr  = {pc_q[ADDR_LEN-1:4], 4'b0000};

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle table from reset, then redirect/stale/reset sequences.
// Latency: memory model answers k cycles after acceptance, k set per phase.
// Backpressure: memory ready is driven per phase.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [ADDR_LEN-1:0] ENTRY = 32'h0000_0100;
    localparam int NV = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic                stall_if;
    logic                prmiss;
    logic [ADDR_LEN-1:0] jmpaddr;
    logic [ADDR_LEN-1:0] npc;
    logic [ADDR_LEN-1:0] pc;
    logic [LINE_LEN-1:0] idata;
    logic                fetch_valid;

    fetch_ctrl_if imem ();

    fetch_ctrl #(.ENTRY_POINT(ENTRY)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_if    (stall_if),
        .prmiss      (prmiss),
        .jmpaddr     (jmpaddr),
        .npc         (npc),
        .pc          (pc),
        .idata       (idata),
        .fetch_valid (fetch_valid),
        .imem        (imem.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                stall;
        logic                miss;
        logic [ADDR_LEN-1:0] jmp;
        int                  step;
        logic                fv;
        logic                rv;
        logic [ADDR_LEN-1:0] pc;
    } vec_t;

    typedef struct {
        logic [ADDR_LEN-1:0] addr;
        int                  due;
    } pend_t;

    vec_t                tv [NV];
    pend_t               pend_q [$];
    logic [ADDR_LEN-1:0] exp_req_q [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   step = 8;
    int   mem_lat = 1;
    int   outstanding = 0;
    int   viol_cnt = 0;
    logic mem_ready = 1'b1;
    logic inject_late = 1'b0;

    // Memory image: each word encodes its own byte address.
    function automatic logic [LINE_LEN-1:0] line_of(input logic [ADDR_LEN-1:0] a);
        logic [ADDR_LEN-1:0] b;
        b = {a[ADDR_LEN-1:4], 4'b0000};
        return {(b + 32'd12) ^ 32'hC0DE_0000, (b + 32'd8) ^ 32'hC0DE_0000,
                (b + 32'd4) ^ 32'hC0DE_0000, b ^ 32'hC0DE_0000};
    endfunction

    task automatic check(input string name, input logic [LINE_LEN-1:0] act,
                         input logic [LINE_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory side: drive ready/response for this cycle and record acceptances.
    task automatic mem_drive();
        imem.imem_req_ready  = mem_ready;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;
        if (reset) begin
            pend_q.delete();
            outstanding = 0;
        end else if (inject_late) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = {4{32'hDEAD_BEEF}};
            inject_late = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = line_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        if (imem.imem_resp_valid) begin
            if (outstanding == 0) begin
                viol_cnt++;
                $display("note: response with no outstanding request at cycle %0d", cyc);
            end else begin
                outstanding--;
            end
        end
        if (!reset && imem.imem_req_valid && imem.imem_req_ready) begin
            pend_q.push_back('{addr: imem.imem_req_addr, due: cyc + mem_lat});
            outstanding++;
        end
    endtask

    // Request scoreboard plus the line-vs-pc invariant on every presented group.
    task automatic monitor();
        if (!reset && imem.imem_req_valid && imem.imem_req_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got %0h expected none (cycle %0d)",
                         imem.imem_req_addr, cyc);
            end else begin
                check("req_addr", imem.imem_req_addr, exp_req_q.pop_front());
            end
        end
        if (fetch_valid) check("idata_matches_pc", idata, line_of(pc));
    endtask

    // One clock: finish this cycle's inputs, sample, advance to the next negedge.
    task automatic tick();
        npc = pc + 32'(step);
        mem_drive();
        monitor();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_fv(input string name);
        int n = 0;
        while (!fetch_valid && n < 30) begin
            tick();
            n++;
        end
        if (!fetch_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: fetch_valid got 0 expected 1 within 30 cycles", name);
        end
    endtask

    // Runs through the accepting cycle, leaving the bench at the first WAIT cycle.
    task automatic wait_accept(input string name);
        int n = 0;
        while (!(imem.imem_req_valid && mem_ready) && n < 30) begin
            tick();
            n++;
        end
        if (!(imem.imem_req_valid && mem_ready)) begin
            checks++;
            errors++;
            $display("FAIL %s: request got none expected one within 30 cycles", name);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         stall miss jmp           step fv   rv   pc
        tv[0]  = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b0, 32'h100};
        tv[1]  = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b1, 32'h100};
        tv[2]  = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b0, 32'h100};
        tv[3]  = '{1'b0, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h100};
        tv[4]  = '{1'b0, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h108};
        tv[5]  = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b1, 32'h110};
        tv[6]  = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b0, 32'h110};
        tv[7]  = '{1'b1, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h110};
        tv[8]  = '{1'b1, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h110};
        tv[9]  = '{1'b1, 1'b1, 32'h118, 8, 1'b1, 1'b0, 32'h110};
        tv[10] = '{1'b1, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h118};
        tv[11] = '{1'b0, 1'b0, 32'h0,   8, 1'b1, 1'b0, 32'h118};
        tv[12] = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b1, 32'h120};
        tv[13] = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b0, 32'h120};
        tv[14] = '{1'b0, 1'b1, 32'h300, 8, 1'b1, 1'b0, 32'h120};
        tv[15] = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b1, 32'h300};
        tv[16] = '{1'b0, 1'b0, 32'h0,   8, 1'b0, 1'b0, 32'h300};
        tv[17] = '{1'b0, 1'b1, 32'h304, 8, 1'b1, 1'b0, 32'h300};
        tv[18] = '{1'b0, 1'b0, 32'h0,   4, 1'b1, 1'b0, 32'h304};
        tv[19] = '{1'b0, 1'b0, 32'h0,   0, 1'b1, 1'b0, 32'h308};

        reset = 1'b1;
        stall_if = 1'b0;
        prmiss = 1'b0;
        jmpaddr = '0;
        npc = '0;
        imem.imem_req_ready  = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;
        @(negedge clk);
        tick();
        tick();

        // Cycle table from reset release: latency 1, memory always ready.
        reset = 1'b0;
        check("reset_idata", idata, '0);
        exp_req_q.push_back(32'h100);
        exp_req_q.push_back(32'h110);
        exp_req_q.push_back(32'h120);
        exp_req_q.push_back(32'h300);
        for (int i = 0; i < NV; i++) begin
            stall_if = tv[i].stall;
            prmiss   = tv[i].miss;
            jmpaddr  = tv[i].jmp;
            step     = tv[i].step;
            check($sformatf("v%0d_fetch_valid", i), fetch_valid, tv[i].fv);
            check($sformatf("v%0d_req_valid", i), imem.imem_req_valid, tv[i].rv);
            check($sformatf("v%0d_pc", i), pc, tv[i].pc);
            if (tv[i].rv) check($sformatf("v%0d_req_addr", i), imem.imem_req_addr,
                                {tv[i].pc[ADDR_LEN-1:4], 4'b0000});
            tick();
        end
        stall_if = 1'b0;
        prmiss   = 1'b0;

        // Redirect while waiting; the stale reply arrives 3 cycles after acceptance.
        mem_lat = 3;
        exp_req_q.push_back(32'h310);
        exp_req_q.push_back(32'h400);
        step = 16;
        tick();
        step = 8;
        wait_accept("stale_req");
        prmiss = 1'b1;
        jmpaddr = 32'h400;
        tick();
        prmiss = 1'b0;
        check("stale_drain_pc", pc, 32'h400);
        check("stale_drain_req_valid", imem.imem_req_valid, 1'b0);
        wait_fv("stale_fv");
        check("stale_fv_pc", pc, 32'h400);
        check("stale_fv_idata", idata, line_of(32'h400));

        // Redirect in the same cycle as the reply.
        mem_lat = 1;
        exp_req_q.push_back(32'h410);
        exp_req_q.push_back(32'h200);
        step = 16;
        tick();
        step = 8;
        wait_accept("same_cycle_req");
        prmiss = 1'b1;
        jmpaddr = 32'h20C;
        tick();
        prmiss = 1'b0;
        check("same_cycle_req_valid", imem.imem_req_valid, 1'b1);
        check("same_cycle_req_addr", imem.imem_req_addr, 32'h200);
        check("same_cycle_fetch_valid", fetch_valid, 1'b0);
        wait_fv("same_cycle_fv");
        check("same_cycle_fv_pc", pc, 32'h20C);
        check("same_cycle_fv_idata", idata, line_of(32'h200));

        // Reset while waiting, then a late reply during IDLE.
        mem_lat = 3;
        exp_req_q.push_back(32'h210);
        exp_req_q.push_back(32'h100);
        step = 16;
        tick();
        step = 8;
        wait_accept("reset_req");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_req_valid", imem.imem_req_valid, 1'b0);
        check("rst_pc", pc, ENTRY);
        check("rst_idata", idata, '0);
        inject_late = 1'b1;
        tick();
        check("rst_req_after_late", imem.imem_req_valid, 1'b1);
        check("rst_req_addr", imem.imem_req_addr, ENTRY);
        wait_fv("rst_fv");
        check("rst_fv_pc", pc, ENTRY);
        check("rst_fv_idata", idata, line_of(ENTRY));
        check("late_resp_flagged", 32'(viol_cnt), 32'd1);

        // Redirect while the request is not yet accepted.
        mem_lat = 1;
        exp_req_q.push_back(32'h500);
        mem_ready = 1'b0;
        step = 16;
        tick();
        step = 8;
        check("noready_req_valid", imem.imem_req_valid, 1'b1);
        check("noready_req_addr", imem.imem_req_addr, 32'h110);
        prmiss = 1'b1;
        jmpaddr = 32'h504;
        tick();
        prmiss = 1'b0;
        check("noready_redirect_addr", imem.imem_req_addr, 32'h500);
        check("noready_redirect_pc", pc, 32'h504);
        mem_ready = 1'b1;
        wait_fv("noready_fv");
        check("noready_fv_pc", pc, 32'h504);
        check("noready_fv_idata", idata, line_of(32'h500));

        check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
